note_scheduler: RTL and testbench

Game-side controller that sequences the ListaValores random source into a drum-note stream for Drums Hero. A programmable beat timer runs the song. On each beat the block samples the 5-bit random value and decides either a rest or a note on a 4-lane mask. It hands the note to the display/judging logic over a valid/ready handshake and tracks song length, completion and dropped notes.

---
 rtl/note_scheduler_pkg.sv | 33 +++
 rtl/note_scheduler_beat_timer.sv | 35 +++
 rtl/note_scheduler.sv | 173 +++++++++++++++++
 tb/tb_note_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/note_scheduler_pkg.sv
// Shared types and helpers for the Drums Hero note scheduler.
// The LANE_LIMIT_EN build option uses lane_limit() to cap chords at two drums.
package note_sched_pkg;

    localparam int LANES    = 4;
    localparam int REST_BIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COUNT  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Keep only the two lowest set bits of a lane mask.
    function automatic logic [LANES-1:0] lane_limit(input logic [LANES-1:0] mask);
        logic [LANES-1:0] kept;
        logic [2:0]       hits;
        kept = {LANES{1'b0}};
        hits = 3'd0;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i] && (hits < 3'd2)) begin
                kept[i] = 1'b1;
                hits    = hits + 3'd1;
            end else begin
                kept[i] = 1'b0;
            end
        end
        return kept;
    endfunction

endpackage

// File: rtl/note_scheduler_beat_timer.sv
// Free-running beat counter: counts 0..period-1 while enabled and wraps.
// terminal flags the last cycle of each beat.
module beat_timer #(
    parameter int BEAT_W = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [BEAT_W-1:0] period,
    output logic              terminal
);

    logic [BEAT_W-1:0] count_r;

    assign terminal = (count_r == (period - BEAT_W'(1)));

    // Beat counter: clear on request, wrap on terminal, otherwise increment while enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {BEAT_W{1'b0}};
        end else if (clr) begin
            count_r <= {BEAT_W{1'b0}};
        end else if (en) begin
            if (terminal) begin
                count_r <= {BEAT_W{1'b0}};
            end else begin
                count_r <= count_r + BEAT_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Drum-note scheduler: turns the ListaValores random value into one note or
// rest per beat and offers each note over a valid/ready handshake.
// Build option: define LANE_LIMIT_EN to reduce chords to their two lowest lanes.
module note_scheduler
    import note_sched_pkg::*;
#(
    parameter int BEAT_W      = 26,
    parameter int BEAT_PERIOD = 12500000,
    parameter int SONG_LEN    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] dificultad,
    input  logic [4:0] random_in,
    output logic       note_valid,
    input  logic       note_ready,
    output logic [3:0] note_lanes,
    output logic [6:0] beat_count,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam logic [BEAT_W-1:0] BASE_PERIOD = BEAT_W'(BEAT_PERIOD);
    localparam logic [6:0]        SONG_LEN_C  = 7'(SONG_LEN);

    state_t            state_r, state_s;
    logic [1:0]        diff_r, diff_s;
    logic [6:0]        beat_count_r, beat_count_s;
    logic              overrun_r, overrun_s;
    logic [LANES-1:0]  lanes_r, lanes_s;
    logic              note_valid_r, busy_r, done_r;
    logic [LANES-1:0]  decoded_s;
    logic [BEAT_W-1:0] period_s;
    logic              terminal_s;
    logic              timer_en_s;
    logic              timer_clr_s;
    logic              last_beat_s;
    logic              is_rest_s;

    assign period_s    = BASE_PERIOD >> diff_r;
    assign timer_en_s  = (state_r == ST_COUNT) || (state_r == ST_SAMPLE) || (state_r == ST_EMIT);
    assign last_beat_s = (beat_count_r == SONG_LEN_C);
    assign is_rest_s   = random_in[REST_BIT] || (random_in[LANES-1:0] == {LANES{1'b0}});

`ifdef LANE_LIMIT_EN
    assign decoded_s = lane_limit(random_in[LANES-1:0]);
`else
    assign decoded_s = random_in[LANES-1:0];
`endif

    beat_timer #(
        .BEAT_W(BEAT_W)
    ) u_beat_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (timer_clr_s),
        .en       (timer_en_s),
        .period   (period_s),
        .terminal (terminal_s)
    );

    // Next-state and next-register decode; stop overrides everything else.
    always_comb begin
        state_s      = state_r;
        diff_s       = diff_r;
        beat_count_s = beat_count_r;
        overrun_s    = overrun_r;
        lanes_s      = lanes_r;
        timer_clr_s  = 1'b0;
        if (stop) begin
            state_s = ST_IDLE;
            lanes_s = {LANES{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    lanes_s = {LANES{1'b0}};
                    if (start) begin
                        state_s      = ST_COUNT;
                        diff_s       = dificultad;
                        beat_count_s = 7'd0;
                        overrun_s    = 1'b0;
                        timer_clr_s  = 1'b1;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_COUNT: begin
                    if (terminal_s) begin
                        state_s = ST_SAMPLE;
                    end else begin
                        state_s = ST_COUNT;
                    end
                end
                ST_SAMPLE: begin
                    beat_count_s = beat_count_r + 7'd1;
                    if (is_rest_s) begin
                        lanes_s = {LANES{1'b0}};
                        if ((beat_count_r + 7'd1) == SONG_LEN_C) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_COUNT;
                        end
                    end else begin
                        lanes_s = decoded_s;
                        state_s = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (note_ready) begin
                        // Handshake wins over a coincident beat boundary.
                        lanes_s = {LANES{1'b0}};
                        if (last_beat_s) begin
                            state_s = ST_DONE;
                        end else if (terminal_s) begin
                            state_s = ST_SAMPLE;
                        end else begin
                            state_s = ST_COUNT;
                        end
                    end else if (terminal_s) begin
                        // Beat ran out with the note still pending: drop it.
                        lanes_s   = {LANES{1'b0}};
                        overrun_s = 1'b1;
                        if (last_beat_s) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_SAMPLE;
                        end
                    end else begin
                        state_s = ST_EMIT;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    lanes_s = {LANES{1'b0}};
                end
            endcase
        end
    end

    // State and output registers; outputs are derived from the next state so they are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            diff_r       <= 2'd0;
            beat_count_r <= 7'd0;
            overrun_r    <= 1'b0;
            lanes_r      <= {LANES{1'b0}};
            note_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            diff_r       <= diff_s;
            beat_count_r <= beat_count_s;
            overrun_r    <= overrun_s;
            lanes_r      <= lanes_s;
            note_valid_r <= (state_s == ST_EMIT);
            busy_r       <= (state_s == ST_COUNT) || (state_s == ST_SAMPLE) || (state_s == ST_EMIT);
            done_r       <= (state_s == ST_DONE);
        end
    end

    assign note_valid = note_valid_r;
    assign note_lanes = lanes_r;
    assign beat_count = beat_count_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed self-checking bench for note_scheduler (BEAT_PERIOD=8, SONG_LEN=4).
// Times below are counted in rising edges after the edge that accepts start (A).
module tb_note_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [1:0] dificultad;
    logic [4:0] random_in;
    logic       note_valid;
    logic       note_ready;
    logic [3:0] note_lanes;
    logic [6:0] beat_count;
    logic       busy;
    logic       done;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_limit;

    note_scheduler #(
        .BEAT_W      (26),
        .BEAT_PERIOD (8),
        .SONG_LEN    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .dificultad (dificultad),
        .random_in  (random_in),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_lanes (note_lanes),
        .beat_count (beat_count),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        dificultad = 2'd0;
        random_in  = 5'd0;
        note_ready = 1'b0;
        tick(2);
        check("rst_valid", {7'd0, note_valid}, 8'd0);
        check("rst_lanes", {4'd0, note_lanes}, 8'd0);
        check("rst_beat",  {1'b0, beat_count}, 8'd0);
        check("rst_busy",  {7'd0, busy}, 8'd0);
        check("rst_done",  {7'd0, done}, 8'd0);
        check("rst_ovr",   {7'd0, overrun}, 8'd0);
        rst_n = 1'b1;
        tick(1);

        // Basic note: SAMPLE after A+8, note_valid only after A+9.
        random_in  = 5'b00101;
        note_ready = 1'b1;
        start      = 1'b1;
        tick(1);
        start = 1'b0;
        check("basic_busy", {7'd0, busy}, 8'd1);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check("basic_quiet", {7'd0, note_valid}, 8'd0);
        end
        tick(1);
        check("basic_valid", {7'd0, note_valid}, 8'd1);
        check("basic_lanes", {4'd0, note_lanes}, 8'h05);
        check("basic_beat",  {1'b0, beat_count}, 8'd1);
        tick(1);
        check("basic_hs_valid", {7'd0, note_valid}, 8'd0);
        check("basic_hs_lanes", {4'd0, note_lanes}, 8'd0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("stop_busy", {7'd0, busy}, 8'd0);
        check("stop_beat_kept", {1'b0, beat_count}, 8'd1);

        // Tempo: period 2, dificultad changed after start must be ignored.
        dificultad = 2'd2;
        random_in  = 5'b00001;
        note_ready = 1'b1;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
        dificultad = 2'd0;
        check("tempo_beat_clr", {1'b0, beat_count}, 8'd0);
        tick(2);
        check("tempo_sample_quiet", {7'd0, note_valid}, 8'd0);
        tick(1);
        check("tempo_valid1", {7'd0, note_valid}, 8'd1);
        check("tempo_lanes1", {4'd0, note_lanes}, 8'h01);
        tick(6);
        check("tempo_valid4", {7'd0, note_valid}, 8'd1);
        check("tempo_beat4",  {1'b0, beat_count}, 8'd4);
        tick(1);
        check("tempo_done", {7'd0, done}, 8'd1);
        check("tempo_busy", {7'd0, busy}, 8'd0);
        check("tempo_lanes_done", {4'd0, note_lanes}, 8'd0);

        // Rest: restart from DONE, two rests in a row.
        dificultad = 2'd0;
        random_in  = 5'b10011;
        start      = 1'b1;
        tick(1);
        start = 1'b0;
        check("rest_done_clr", {7'd0, done}, 8'd0);
        check("rest_beat_clr", {1'b0, beat_count}, 8'd0);
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            check("rest1_quiet", {7'd0, note_valid}, 8'd0);
        end
        random_in = 5'b00000;
        for (int k = 10; k <= 18; k++) begin
            tick(1);
            check("rest2_quiet", {7'd0, note_valid}, 8'd0);
        end
        check("rest_beat2", {1'b0, beat_count}, 8'd2);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;

        // Backpressure: note held through the beat, then dropped.
        random_in  = 5'b01000;
        note_ready = 1'b0;
        start      = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
        check("bp_valid_start", {7'd0, note_valid}, 8'd1);
        tick(6);
        check("bp_valid_held", {7'd0, note_valid}, 8'd1);
        check("bp_lanes", {4'd0, note_lanes}, 8'h08);
        check("bp_no_ovr_yet", {7'd0, overrun}, 8'd0);
        tick(1);
        check("bp_dropped", {7'd0, note_valid}, 8'd0);
        check("bp_ovr", {7'd0, overrun}, 8'd1);
        check("bp_beat1", {1'b0, beat_count}, 8'd1);
        tick(1);
        check("bp_next_valid", {7'd0, note_valid}, 8'd1);
        check("bp_beat2", {1'b0, beat_count}, 8'd2);
        tick(23);
        check("bp_done", {7'd0, done}, 8'd1);
        check("bp_ovr_kept", {7'd0, overrun}, 8'd1);
        check("bp_beat4", {1'b0, beat_count}, 8'd4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("bp_restart_ovr", {7'd0, overrun}, 8'd0);
        check("bp_restart_busy", {7'd0, busy}, 8'd1);

        // Abort during EMIT.
        tick(9);
        check("abort_pre_valid", {7'd0, note_valid}, 8'd1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("abort_valid", {7'd0, note_valid}, 8'd0);
        check("abort_busy",  {7'd0, busy}, 8'd0);
        check("abort_beat",  {1'b0, beat_count}, 8'd1);

        // stop and start together in DONE: stop wins.
        dificultad = 2'd2;
        random_in  = 5'b00001;
        note_ready = 1'b1;
        start      = 1'b1;
        tick(1);
        start = 1'b0;
        tick(10);
        check("ss_done", {7'd0, done}, 8'd1);
        stop  = 1'b1;
        start = 1'b1;
        tick(1);
        stop  = 1'b0;
        start = 1'b0;
        check("ss_done_clr", {7'd0, done}, 8'd0);
        check("ss_busy", {7'd0, busy}, 8'd0);
        check("ss_beat_kept", {1'b0, beat_count}, 8'd4);
        tick(1);
        check("ss_still_idle", {7'd0, busy}, 8'd0);

        // Lane limit on a full chord.
`ifdef LANE_LIMIT_EN
        exp_limit = 4'b0011;
`else
        exp_limit = 4'b1111;
`endif
        dificultad = 2'd0;
        random_in  = 5'b01111;
        note_ready = 1'b0;
        start      = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
        check("limit_valid", {7'd0, note_valid}, 8'd1);
        check("limit_lanes", {4'd0, note_lanes}, {4'd0, exp_limit});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
